// File: rtl/image_mem_writer_pkg.sv
// Shared definitions for the image RAM writer and the display reader: FSM encoding,
// default pixel base address and the RAM offsets of the four header bytes.
package image_mem_writer_pkg;

  localparam int unsigned AddrW = 18;
  localparam logic [AddrW-1:0] BaseAddress = 18'h10;

  localparam int unsigned HdrOffWidthHi  = 0;
  localparam int unsigned HdrOffWidthLo  = 1;
  localparam int unsigned HdrOffHeightHi = 2;
  localparam int unsigned HdrOffHeightLo = 3;

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StHdrWh  = 4'd1;
  localparam logic [3:0] StHdrWl  = 4'd2;
  localparam logic [3:0] StHdrHh  = 4'd3;
  localparam logic [3:0] StHdrHl  = 4'd4;
  localparam logic [3:0] StCheck  = 4'd5;
  localparam logic [3:0] StPixels = 4'd6;
  localparam logic [3:0] StDone   = 4'd7;
  localparam logic [3:0] StError  = 4'd8;

  // States in which a stream byte may be consumed.
  function automatic logic state_accepts(input logic [3:0] st);
    case (st)
      StHdrWh, StHdrWl, StHdrHh, StHdrHl, StPixels: state_accepts = 1'b1;
      default:                                      state_accepts = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/image_mem_writer.sv
// Parses a width/height header followed by raster pixels from a byte stream and writes
// header and pixels into RAM with a one-cycle registered write port.
module image_mem_writer
  import image_mem_writer_pkg::*;
#(
  parameter int unsigned       ADDR_W       = AddrW,
  parameter logic [ADDR_W-1:0] BASE_ADDRESS = ADDR_W'(BaseAddress),
  parameter int unsigned       MAX_PIXELS   = 2**18 - 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] wraddress,
  output logic [7:0]        data,
  output logic              wren,
  output logic [15:0]       img_width,
  output logic [15:0]       img_height,
  output logic              busy,
  output logic              done,
  output logic              error
);

  logic [3:0]        state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       width_q, width_d;
  logic [15:0]       height_q, height_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [31:0]       total_q, total_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;

  logic        accept;
  logic [31:0] product;
  logic        last_pixel;

  assign in_ready   = state_accepts(state_q);
  assign accept     = in_valid & in_ready;
  assign product    = 32'(width_q) * 32'(height_q);
  assign last_pixel = (32'(cnt_q) + 32'd1) == total_q;

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    width_d  = width_q;
    height_d = height_q;
    cnt_d    = cnt_q;
    total_d  = total_q;
    wren_d   = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;

    // Every accepted byte, header or pixel, is mirrored to RAM on the next cycle.
    if (accept) begin
      wren_d  = 1'b1;
      wdata_d = in_data;
    end

    case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d = StHdrWh;
          cnt_d   = '0;
        end
      end
      StHdrWh: begin
        if (accept) begin
          hi_d    = in_data;
          waddr_d = ADDR_W'(HdrOffWidthHi);
          state_d = StHdrWl;
        end
      end
      StHdrWl: begin
        if (accept) begin
          width_d = {hi_q, in_data};
          waddr_d = ADDR_W'(HdrOffWidthLo);
          state_d = StHdrHh;
        end
      end
      StHdrHh: begin
        if (accept) begin
          hi_d    = in_data;
          waddr_d = ADDR_W'(HdrOffHeightHi);
          state_d = StHdrHl;
        end
      end
      StHdrHl: begin
        if (accept) begin
          height_d = {hi_q, in_data};
          waddr_d  = ADDR_W'(HdrOffHeightLo);
          state_d  = StCheck;
        end
      end
      StCheck: begin
        total_d = product;
        if (product == 32'd0 || product > MAX_PIXELS) begin
          state_d = StError;
        end else begin
          state_d = StPixels;
        end
      end
      StPixels: begin
        if (accept) begin
          waddr_d = BASE_ADDRESS + cnt_q;
          cnt_d   = cnt_q + 1'b1;
          if (last_pixel) begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      hi_q     <= '0;
      width_q  <= '0;
      height_q <= '0;
      cnt_q    <= '0;
      total_q  <= '0;
      wren_q   <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      width_q  <= width_d;
      height_q <= height_d;
      cnt_q    <= cnt_d;
      total_q  <= total_d;
      wren_q   <= wren_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign wren       = wren_q;
  assign wraddress  = waddr_q;
  assign data       = wdata_q;
  assign img_width  = width_q;
  assign img_height = height_q;
  assign busy       = (state_q != StIdle) && (state_q != StDone) && (state_q != StError);
  assign done       = (state_q == StDone);
  assign error      = (state_q == StError);

endmodule

// File: tb/tb_image_mem_writer.sv
// Self-checking bench for image_mem_writer: streams are generated from width/height and
// the expected RAM write list is derived from the stream format alone.
module tb_image_mem_writer;

  localparam int unsigned AW   = 18;
  localparam int unsigned BASE = 16;
  localparam int unsigned MAXP = 262128;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] wraddress;
  logic [7:0]    data;
  logic          wren;
  logic [15:0]   img_width;
  logic [15:0]   img_height;
  logic          busy;
  logic          done;
  logic          error;

  image_mem_writer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wraddress  (wraddress),
    .data       (data),
    .wren       (wren),
    .img_width  (img_width),
    .img_height (img_height),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  logic [AW+7:0] wr_q[$];
  logic [AW+7:0] exp_q[$];
  logic [7:0]    stim_q[$];
  logic [7:0]    pix_q[$];
  logic          prev_acc = 1'b0;

  // Write monitor: a write must appear exactly in the cycle after each accept.
  always @(negedge clk) begin
    if (!rst) begin
      prev_acc <= 1'b0;
    end else begin
      vecs++;
      if (wren !== prev_acc) begin
        errs++;
        $display("FAIL wren_timing t=%0t got %b want %b", $time, wren, prev_acc);
      end
      if (wren === 1'b1) wr_q.push_back({wraddress, data});
      prev_acc <= in_valid && in_ready;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // mode 0: valid always, 1: every other cycle, 2: random gaps. start_idx >= 0 pulses start
  // once when that byte index is being offered.
  task automatic send_stim(input int mode, input int start_idx, output bit completed);
    int  idx;
    int  budget;
    bit  acc;
    bit  pulsed;
    idx = 0;
    budget = 0;
    pulsed = 1'b0;
    while (idx < stim_q.size() && budget < 8 * stim_q.size() + 50) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (budget % 2) == 0;
        default: in_valid = $urandom_range(0, 99) >= 30;
      endcase
      in_data = stim_q[idx];
      if (!pulsed && start_idx >= 0 && idx == start_idx) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (acc) idx++;
      budget++;
    end
    in_valid = 1'b0;
    completed = (idx == stim_q.size());
  endtask

  task automatic run_load(input string name, input int w, input int h, input int mode,
                          input int start_idx);
    logic [15:0] w16;
    logic [15:0] h16;
    int          total;
    bit          ok;
    bit          completed;
    w16 = 16'(w);
    h16 = 16'(h);
    total = w * h;
    ok = (total != 0) && (total <= MAXP);
    stim_q.delete();
    exp_q.delete();
    stim_q.push_back(w16[15:8]);
    stim_q.push_back(w16[7:0]);
    stim_q.push_back(h16[15:8]);
    stim_q.push_back(h16[7:0]);
    for (int k = 0; k < 4; k++) exp_q.push_back({18'(k), stim_q[k]});
    if (ok) begin
      if (pix_q.size() == 0) begin
        for (int n = 0; n < total; n++) pix_q.push_back(8'($urandom));
      end
      for (int n = 0; n < total; n++) begin
        stim_q.push_back(pix_q[n]);
        exp_q.push_back({18'(BASE + n), pix_q[n]});
      end
    end
    pix_q.delete();
    wr_q.delete();

    pulse_start();
    send_stim(mode, start_idx, completed);
    vecs++;
    if (!completed) begin
      errs++;
      $display("FAIL %s stream_timeout got %0d bytes unsent want 0", name, stim_q.size());
    end
    vecs++;
    if (in_ready !== 1'b0) begin
      errs++;
      $display("FAIL %s in_ready_after_last got %b want 0", name, in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if (done !== ok || error !== !ok || busy !== 1'b0) begin
      errs++;
      $display("FAIL %s status got done=%b error=%b busy=%b want done=%b error=%b busy=0",
               name, done, error, busy, ok, !ok);
    end
    vecs++;
    if (in_ready !== 1'b0) begin
      errs++;
      $display("FAIL %s in_ready_idle got %b want 0", name, in_ready);
    end
    vecs++;
    if (img_width !== w16 || img_height !== h16) begin
      errs++;
      $display("FAIL %s dims got %0dx%0d want %0dx%0d", name, img_width, img_height, w16, h16);
    end
    vecs++;
    if (wr_q.size() != exp_q.size()) begin
      errs++;
      $display("FAIL %s write_count got %0d want %0d", name, wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      vecs++;
      if (wr_q[i] !== exp_q[i]) begin
        errs++;
        $display("FAIL %s write[%0d] got addr=%h data=%h want addr=%h data=%h", name, i,
                 wr_q[i][AW+7:8], wr_q[i][7:0], exp_q[i][AW+7:8], exp_q[i][7:0]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h5a;
    #23;
    vecs++;
    if (wren !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        error !== 1'b0) begin
      errs++;
      $display("FAIL reset_flags got wren=%b rdy=%b busy=%b done=%b err=%b want all 0",
               wren, in_ready, busy, done, error);
    end
    vecs++;
    if (wraddress !== '0 || data !== 8'h00 || img_width !== 16'h0 || img_height !== 16'h0) begin
      errs++;
      $display("FAIL reset_values got addr=%h data=%h w=%h h=%h want all 0",
               wraddress, data, img_width, img_height);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errs++;
      $display("FAIL idle_after_reset got busy=%b rdy=%b want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_load_2x2();
    pix_q = '{8'haa, 8'hbb, 8'hcc, 8'hdd};
    run_load("load_2x2", 2, 2, 0, -1);
  endtask

  task automatic test_gaps();
    pix_q = '{8'haa, 8'hbb, 8'hcc, 8'hdd};
    run_load("gaps_2x2", 2, 2, 1, -1);
  endtask

  task automatic test_errors();
    run_load("zero_width", 0, 5, 0, -1);
    run_load("too_many", 1024, 256, 2, -1);
  endtask

  task automatic test_start_ignored();
    run_load("start_in_pixels", 3, 3, 0, 6);
    run_load("start_in_header", 2, 3, 2, 1);
  endtask

  task automatic test_reset_midload();
    bit completed;
    stim_q.delete();
    exp_q.delete();
    stim_q = '{8'h00, 8'h04, 8'h00, 8'h04};
    for (int k = 0; k < 4; k++) exp_q.push_back({18'(k), stim_q[k]});
    for (int n = 0; n < 3; n++) begin
      stim_q.push_back(8'($urandom));
      exp_q.push_back({18'(BASE + n), stim_q[4 + n]});
    end
    wr_q.delete();
    pulse_start();
    send_stim(0, -1, completed);
    #2;
    vecs++;
    if (!completed || wren !== 1'b1) begin
      errs++;
      $display("FAIL midload_third_write got sent=%b wren=%b want 1 1", completed, wren);
    end
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    vecs++;
    if (wren !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        error !== 1'b0 || wraddress !== '0 || img_width !== 16'h0) begin
      errs++;
      $display("FAIL midload_reset got wren=%b rdy=%b busy=%b addr=%h w=%h want all 0",
               wren, in_ready, busy, wraddress, img_width);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if (wr_q.size() != exp_q.size()) begin
      errs++;
      $display("FAIL midload_write_count got %0d want %0d", wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      vecs++;
      if (wr_q[i] !== exp_q[i]) begin
        errs++;
        $display("FAIL midload_write[%0d] got %h want %h", i, wr_q[i], exp_q[i]);
      end
    end
    run_load("after_reset_2x2", 2, 2, 0, -1);
  endtask

  task automatic test_random();
    int w;
    int h;
    for (int it = 0; it < 8; it++) begin
      w = $urandom_range(1, 6);
      h = $urandom_range(1, 6);
      if (it == 5) h = 0;
      run_load("random", w, h, $urandom_range(0, 2), -1);
    end
  endtask

  initial begin
    test_reset();
    test_load_2x2();
    test_gaps();
    test_errors();
    test_reset_midload();
    test_start_ignored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
